// File: rtl/mem_arbiter2_pkg.sv
// mem_arb_pkg: shared types and constants for the two-port memory arbiter.
// FSM state constants, read/write direction encoding and default bus widths.
package mem_arb_pkg;

    localparam int DEF_AW = 6;
    localparam int DEF_DW = 4;

    // Memory ReadWrite pin encoding
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // 2-bit FSM state encoding, kept as plain constants for legacy tools
    typedef logic [1:0] state_t;
    localparam state_t IDLE   = 2'd0;
    localparam state_t ACCESS = 2'd1;
    localparam state_t DONE   = 2'd2;

endpackage

// File: rtl/mem_arbiter2_if.sv
// mem_arb_if: client handshake and memory pin bundle for mem_arbiter2.
// slave = arbiter side, master = clients plus memory instance.
interface mem_arb_if
    import mem_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);
    logic          req0;
    logic          rw0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          req1;
    logic          rw1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          ack0;
    logic          ack1;
    logic [DW-1:0] rdata;
    logic [1:0]    gnt;
    logic          busy;
    logic          mem_enable;
    logic          mem_rw;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    modport slave (
        input  req0, rw0, addr0, wdata0,
        input  req1, rw1, addr1, wdata1,
        input  mem_dout,
        output ack0, ack1, rdata, gnt, busy,
        output mem_enable, mem_rw, mem_addr, mem_din
    );

    modport master (
        output req0, rw0, addr0, wdata0,
        output req1, rw1, addr1, wdata1,
        output mem_dout,
        input  ack0, ack1, rdata, gnt, busy,
        input  mem_enable, mem_rw, mem_addr, mem_din
    );
endinterface

// File: rtl/mem_arbiter2_rr_pick2.sv
// rr_pick2: combinational two-way pick, one-hot result.
// Ties go to the port that did not win last time; with
// MEM_ARB_FIXED_PRIO_EN defined, ties always go to port 0.
module rr_pick2 (
    input  logic       req0,
    input  logic       req1,
    input  logic       last,
    output logic [1:0] gnt_oh
);
    // Lone requester wins outright; only a tie consults the pointer
    always_comb begin
        gnt_oh = 2'b00;
        if (req0 && !req1)
            gnt_oh = 2'b01;
        else if (!req0 && req1)
            gnt_oh = 2'b10;
        else if (req0 && req1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            gnt_oh = 2'b01;
`else
            gnt_oh = last ? 2'b01 : 2'b10;
`endif
        end
    end
endmodule

// File: rtl/mem_arbiter2.sv
// mem_arbiter2: two-client arbiter/sequencer for a 64x4 single-port memory.
// IDLE picks and latches a command, ACCESS drives one memory cycle, DONE
// pulses the winner's ack. Optional MEM_ARB_FIXED_PRIO_EN (in rr_pick2)
// swaps round-robin for fixed port-0 priority.
module mem_arbiter2
    import mem_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  logic   clk,
    input  logic   rst,
    mem_arb_if.slave bus
);
    state_t        state;
    logic [1:0]    gnt_q;
    logic [1:0]    pick;
    logic          last;
    logic          cmd_rw;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [DW-1:0] rdata_q;

    rr_pick2 u_pick (
        .req0   (bus.req0),
        .req1   (bus.req1),
        .last   (last),
        .gnt_oh (pick)
    );

    // Sequencer FSM: grant, one access cycle, one ack cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt_q <= 2'b00;
            last  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (|pick) begin
                        gnt_q <= pick;
                        state <= ACCESS;
                    end
                end
                ACCESS: state <= DONE;
                DONE: begin
                    last  <= gnt_q[1];
                    gnt_q <= 2'b00;
                    state <= IDLE;
                end
                default: begin
                    gnt_q <= 2'b00;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Command capture at grant; these also hold the memory pins between accesses
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_rw    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
        end else if (state == IDLE && |pick) begin
            cmd_rw    <= pick[1] ? bus.rw1    : bus.rw0;
            cmd_addr  <= pick[1] ? bus.addr1  : bus.addr0;
            cmd_wdata <= pick[1] ? bus.wdata1 : bus.wdata0;
        end
    end

    // Read data capture at the end of a read ACCESS; held until the next read
    always_ff @(posedge clk) begin
        if (rst)
            rdata_q <= '0;
        else if (state == ACCESS && cmd_rw == RW_READ)
            rdata_q <= bus.mem_dout;
    end

    // Output decode
    always_comb begin
        bus.gnt        = gnt_q;
        bus.busy       = (state == ACCESS) || (state == DONE);
        bus.ack0       = (state == DONE) && gnt_q[0];
        bus.ack1       = (state == DONE) && gnt_q[1];
        bus.rdata      = rdata_q;
        bus.mem_enable = (state == ACCESS);
        bus.mem_rw     = cmd_rw;
        bus.mem_addr   = cmd_addr;
        bus.mem_din    = cmd_wdata;
    end
endmodule

// File: tb/tb_mem_arbiter2.sv
// tb_mem_arbiter2: directed bench for mem_arbiter2 with a behavioural
// 64x4 memory (combinational read, clocked write).
module tb_mem_arbiter2;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nvec = 0;
    int   nerr = 0;
    int   cnt0 = 0;
    int   cnt1 = 0;
    bit   both_seen = 1'b0;
    logic [3:0] mem [64];

    mem_arb_if #(.AW(6), .DW(4)) bus ();

    mem_arbiter2 #(.AW(6), .DW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.mem_dout = mem[bus.mem_addr];
    always @(posedge clk)
        if (bus.mem_enable && bus.mem_rw == RW_WRITE)
            mem[bus.mem_addr] <= bus.mem_din;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise a request, wait (bounded) for any ack, drop the request on that cycle
    task automatic xfer(input int p, input logic rw, input logic [5:0] a,
                        input logic [3:0] d, output logic [3:0] rd,
                        output int who, output int lat);
        if (p == 0) begin
            bus.req0 = 1'b1; bus.rw0 = rw; bus.addr0 = a; bus.wdata0 = d;
        end else begin
            bus.req1 = 1'b1; bus.rw1 = rw; bus.addr1 = a; bus.wdata1 = d;
        end
        who = -1;
        lat = 0;
        for (int c = 0; c < 12 && who < 0; c++) begin
            tick();
            lat++;
            if (bus.ack0 && bus.ack1) both_seen = 1'b1;
            if (bus.ack0) begin who = 0; cnt0++; end
            else if (bus.ack1) begin who = 1; cnt1++; end
        end
        rd = bus.rdata;
        if (p == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
    endtask

    initial begin
        logic [3:0]  rd;
        int          who, lat, n;
        int          order [4];
        int          exp_order [4];
        logic [20:0] outs;

        bus.req0 = 0; bus.rw0 = 0; bus.addr0 = 0; bus.wdata0 = 0;
        bus.req1 = 0; bus.rw1 = 0; bus.addr1 = 0; bus.wdata1 = 0;
        for (int i = 0; i < 64; i++) mem[i] = 4'h0;

        // Reset state
        tick(); tick();
        rst = 1'b0;
        tick();
        outs = {bus.gnt, bus.busy, bus.ack0, bus.ack1, bus.mem_enable,
                bus.mem_rw, bus.mem_addr, bus.mem_din, bus.rdata};
        chk("reset_outputs", 32'(outs), 32'h0);

        // Single write, step by step
        bus.req0 = 1; bus.rw0 = 0; bus.addr0 = 6'd5; bus.wdata0 = 4'hA;
        tick();
        chk("wr_enable",  32'(bus.mem_enable), 32'h1);
        chk("wr_addr",    32'(bus.mem_addr),   32'd5);
        chk("wr_din",     32'(bus.mem_din),    32'hA);
        chk("wr_rw",      32'(bus.mem_rw),     32'h0);
        chk("wr_gnt_acc", 32'(bus.gnt),        32'b01);
        chk("wr_busy",    32'(bus.busy),       32'h1);
        chk("wr_noack",   32'({bus.ack0, bus.ack1}), 32'h0);
        bus.addr0 = 6'd7; bus.wdata0 = 4'h3;   // late change must be ignored
        tick();
        chk("wr_en_off",  32'(bus.mem_enable), 32'h0);
        chk("wr_ack0",    32'({bus.ack0, bus.ack1}), 32'b10);
        chk("wr_gnt_dn",  32'(bus.gnt),        32'b01);
        bus.req0 = 0;
        tick();
        chk("wr_idle",    32'({bus.gnt, bus.busy, bus.ack0}), 32'h0);
        chk("wr_addr_hold", 32'(bus.mem_addr), 32'd5);
        chk("wr_din_hold",  32'(bus.mem_din),  32'hA);

        // Readback on port 1, then rdata holds
        xfer(1, RW_READ, 6'd5, 4'h0, rd, who, lat);
        chk("rb_who",  32'(who), 32'd1);
        chk("rb_lat",  32'(lat), 32'd2);
        chk("rb_data", 32'(rd),  32'hA);
        repeat (5) tick();
        chk("rb_hold", 32'(bus.rdata), 32'hA);

        // Simultaneous requests held for four transactions
        rst = 1'b1; tick(); rst = 1'b0;
        bus.req0 = 1; bus.rw0 = RW_READ; bus.addr0 = 6'd1;
        bus.req1 = 1; bus.rw1 = RW_READ; bus.addr1 = 6'd2;
        n = 0;
        for (int c = 0; c < 30 && n < 4; c++) begin
            tick();
            if (bus.ack0) begin order[n] = 0; n++; end
            else if (bus.ack1) begin order[n] = 1; n++; end
        end
        bus.req0 = 0; bus.req1 = 0;
`ifdef MEM_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0};
`else
        exp_order = '{0, 1, 0, 1};
`endif
        chk("tie_count", 32'(n), 32'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("tie_order%0d", i), 32'(order[i]), 32'(exp_order[i]));
        tick(); tick();

        // Fill 0..9 through port 0, verify through port 1
        cnt0 = 0; cnt1 = 0; both_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            xfer(0, RW_WRITE, 6'(i), 4'(i), rd, who, lat);
            chk($sformatf("fill_who%0d", i), 32'(who), 32'd0);
        end
        for (int i = 0; i < 10; i++) begin
            xfer(1, RW_READ, 6'(i), 4'h0, rd, who, lat);
            chk($sformatf("verify_data%0d", i), 32'(rd), 32'(i));
        end
        chk("fill_acks0", 32'(cnt0), 32'd10);
        chk("fill_acks1", 32'(cnt1), 32'd10);
        chk("never_both_acks", 32'(both_seen), 32'h0);
        tick(); tick();

        // Reset during ACCESS of a write to 63
        bus.req0 = 1; bus.rw0 = RW_WRITE; bus.addr0 = 6'd63; bus.wdata0 = 4'h5;
        tick();
        chk("abort_in_access", 32'(bus.mem_enable), 32'h1);
        rst = 1'b1; bus.req0 = 0;
        tick();
        outs = {bus.gnt, bus.busy, bus.ack0, bus.ack1, bus.mem_enable,
                bus.mem_rw, bus.mem_addr, bus.mem_din, bus.rdata};
        chk("abort_outputs", 32'(outs), 32'h0);
        rst = 1'b0;
        tick();
        chk("abort_no_ack", 32'({bus.ack0, bus.ack1}), 32'h0);
        bus.req0 = 1; bus.rw0 = RW_READ; bus.addr0 = 6'd0;
        bus.req1 = 1; bus.rw1 = RW_READ; bus.addr1 = 6'd0;
        tick();
        chk("abort_tie_gnt", 32'(bus.gnt), 32'b01);
        bus.req1 = 0;
        tick();
        bus.req0 = 0;
        tick();

        // Address boundaries 63 and 0
        xfer(0, RW_WRITE, 6'd63, 4'hF, rd, who, lat);
        chk("bnd_wr_who", 32'(who), 32'd0);
        xfer(1, RW_READ, 6'd63, 4'h0, rd, who, lat);
        chk("bnd_rd63", 32'(rd), 32'hF);
        xfer(1, RW_READ, 6'd0, 4'h0, rd, who, lat);
        chk("bnd_rd0", 32'(rd), 32'h0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/mem_arbiter2.md
Name: mem_arbiter2

Overview:
- Two-requester arbiter and sequencer for the 64x4 single-port memory (Enable, ReadWrite with 1=read and 0=write, Address[5:0], DataIn[3:0], DataOut[3:0]).
- Arbitrates between two clients using round-robin.
- Latches the winner's command, drives one memory access, and returns read data with a one-cycle ack.
- Sits between the memory instance and two client FSMs, for example a fill engine and a readback or display engine.

Parameters:
- AW, 6, memory address width.
- DW, 4, memory data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req0  in  1  client 0 request, level; held until ack0.
- rw0  in  1  client 0 direction: 1=read, 0=write.
- addr0  in  AW  client 0 address.
- wdata0  in  DW  client 0 write data.
- req1  in  1  client 1 request.
- rw1  in  1  client 1 direction.
- addr1  in  AW  client 1 address.
- wdata1  in  DW  client 1 write data.
- ack0  out  1  one-cycle completion pulse to client 0.
- ack1  out  1  one-cycle completion pulse to client 1.
- rdata  out  DW  read data; valid while ack0 or ack1 is high for a read.
- gnt  out  2  one-hot current owner, 00 when idle.
- busy  out  1  high in ACCESS and DONE.
- mem_enable  out  1  memory Enable.
- mem_rw  out  1  memory ReadWrite.
- mem_addr  out  AW  memory Address.
- mem_din  out  DW  memory DataIn.
- mem_dout  in  DW  memory DataOut.

Behaviour:
- Reset values: state=IDLE, all outputs 0, last-grant pointer last=1 so port 0 wins the first tie.
- rst overrides everything, including mid-ACCESS or mid-DONE. No ack is issued for an aborted transaction, and the client must re-request.
- States: IDLE, ACCESS, DONE. Encoding is 2-bit.
- IDLE:
  - mem_enable=0.
  - If any req is high, pick the winner, latch rw/addr/wdata into cmd registers, set gnt, and go to ACCESS. Otherwise stay in IDLE.
- Pick rule (round-robin):
  - If only one req is high, that port wins.
  - If both are high, the port not equal to last wins.
- ACCESS (exactly 1 cycle):
  - mem_enable=1; mem_rw, mem_addr and mem_din come from the latched cmd registers.
  - On a read, rdata <= mem_dout at the end of this cycle.
  - Go to DONE.
- DONE (exactly 1 cycle):
  - mem_enable=0; ack of the granted port =1; last <= granted port.
  - Go to IDLE; gnt clears on entry to IDLE.
- Latency: req sampled high in IDLE at edge N, then ACCESS in N..N+1, then ack high in cycle N+2. Minimum period between grants is 3 cycles.
- Client rule: the client deasserts req, or presents a new command, on the edge at which it samples ack=1. req still high in IDLE is treated as a new request.
- Commands are latched at grant time. Changes to addr/wdata/rw after grant are ignored.
- rdata holds its last read value across writes and idle cycles. It is never cleared except by rst.
- mem_rw and mem_addr hold their last value when mem_enable=0. mem_din likewise holds.
- Starvation bound: with both clients requesting continuously, grants strictly alternate, so each client waits at most 6 cycles.
- Both addresses at the boundaries 0 and 63 pass through unmodified; there is no address arithmetic.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, port 0 always wins ties. last is still updated but not used. A continuously requesting port 0 may starve port 1; this is accepted.
- Undefined: round-robin as specified above.

Decomposition:
- Package mem_arb_pkg holds:
  - state typedef (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2);
  - constants RW_READ=1'b1 and RW_WRITE=1'b0;
  - default AW=6 and DW=4.
- Sub-module rr_pick2 is the combinational 2-way pick from (req0, req1, last). It returns a one-hot grant and contains the MEM_ARB_FIXED_PRIO_EN selection.
- The top module holds the FSM, cmd registers, rdata, last and the memory drive.

Test Plan:
- Reset then single write: req0=1, rw0=0, addr0=5, wdata0=4'hA. Required: mem_enable=1 with addr 5 and din A for 1 cycle, ack0 exactly 2 cycles after grant, gnt=01 during busy.
- Readback: after the write, req1=1, rw1=1, addr1=5. Required: ack1 pulse with rdata=4'hA, and rdata still 4'hA 5 cycles later.
- Simultaneous requests after reset, both held for 4 transactions. Required grant order: port0, port1, port0, port1. With MEM_ARB_FIXED_PRIO_EN defined: port0, port0, port0, port0.
- Fill and verify: client0 writes addr 0..9 with data 0..9, then client1 reads addr 0..9. Required: rdata = 0..9 in order, 10 acks on each port, never both acks high.
- Reset mid-operation: assert rst during ACCESS of a write to addr 63. Required: no ack, all outputs 0 the next cycle, and a subsequent tie granted to port 0.
- Boundary: write 4'hF at addr 63, then read addr 63 and addr 0 (0 previously written with 4'h0). Required: rdata F, then 0.
